// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the pipeline registers:
// IF/ID control codes (same encoding the hazard controller emits),
// the injected bubble instruction and the default reset PC.
package fetch_stage_pkg;

  // Pipeline-register control codes; 2'b11 is reserved and behaves as STOP.
  localparam logic [1:0] DATA_CTRL_NORMAL = 2'b00;
  localparam logic [1:0] DATA_CTRL_STOP   = 2'b01;
  localparam logic [1:0] DATA_CTRL_FLUSH  = 2'b10;

  // addi x0,x0,0 -- the canonical bubble.
  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0013;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with NORMAL / STOP / FLUSH handling.
// Carries a valid bit, a PC and one data word; a flush or an empty load
// leaves the BUBBLE word behind while keeping the old PC.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ctrl,
  input  logic             load_valid,
  input  logic [31:0]      load_pc,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [31:0]      pc,
  output logic [WIDTH-1:0] data
);

  // Register update: flush injects a bubble, normal loads, anything else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= BUBBLE;
    end else begin
      case (ctrl)
        DATA_CTRL_FLUSH: begin
          valid <= 1'b0;
          data  <= BUBBLE;
        end
        DATA_CTRL_NORMAL: begin
          valid <= load_valid;
          if (load_valid) begin
            pc   <= load_pc;
            data <= load_data;
          end else begin
            data <= BUBBLE;
          end
        end
        default: ; // STOP and the reserved code hold the register
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, synchronous ROM interface,
// one-entry skid buffer for words that return while ID is stalled, and
// the IF/ID pipeline register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        keep_i,
  input  logic        back_i,
  input  logic [31:0] back_pc_i,
  input  logic [1:0]  IF_ID_data_ctrl_i,
  output logic        irom_en_o,
  output logic [31:0] irom_addr_o,
  input  logic [31:0] irom_data_i,
  output logic [31:0] ID_pc_o,
  output logic [31:0] ID_pc4_o,
  output logic [31:0] ID_irom_o,
  output logic        ID_valid_o
);

  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;
  logic        inflight_q;
  logic        skid_valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_inst_q;

  logic        fetch_en;
  logic        skid_clear;
  logic        cand_valid;
  logic [31:0] cand_pc;
  logic [31:0] cand_inst;

  // A new read is issued only when nothing holds or redirects the PC.
  assign fetch_en    = !rst_i && !keep_i && !back_i;
  assign irom_en_o   = fetch_en;
  assign irom_addr_o = pc_q;

  // Any redirect, flush or normal advance empties the skid buffer.
  assign skid_clear = back_i
                   || (IF_ID_data_ctrl_i == DATA_CTRL_FLUSH)
                   || (IF_ID_data_ctrl_i == DATA_CTRL_NORMAL);

  // Fetch candidate: the skid entry is older than the in-flight word.
  always_comb begin
    cand_valid = 1'b0;
    cand_pc    = fetch_pc_q;
    cand_inst  = irom_data_i;
    if (skid_valid_q) begin
      cand_valid = 1'b1;
      cand_pc    = skid_pc_q;
      cand_inst  = skid_inst_q;
    end else if (inflight_q) begin
      cand_valid = 1'b1;
    end
  end

  // PC sequencing and in-flight tracking; a redirect discards the pending read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else if (fetch_en) begin
      pc_q       <= pc_q + 32'd4;
      fetch_pc_q <= pc_q;
      inflight_q <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
      if (back_i) begin
        pc_q <= word_align(back_pc_i);
      end
    end
  end

  // Skid buffer: park the returning ROM word while IF/ID is stopped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
    end else if (skid_clear) begin
      skid_valid_q <= 1'b0;
    end else if (!skid_valid_q && inflight_q) begin
      skid_valid_q <= 1'b1;
      skid_pc_q    <= fetch_pc_q;
      skid_inst_q  <= irom_data_i;
    end
  end

  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;

  if_id_reg #(
    .WIDTH  (32),
    .BUBBLE (NOP_INST)
  ) u_if_id (
    .clk        (clk_i),
    .rst        (rst_i),
    .ctrl       (IF_ID_data_ctrl_i),
    .load_valid (cand_valid),
    .load_pc    (cand_pc),
    .load_data  (cand_inst),
    .valid      (id_valid_q),
    .pc         (id_pc_q),
    .data       (id_inst_q)
  );

  assign ID_pc_o    = id_pc_q;
  assign ID_pc4_o   = id_pc_q + 32'd4;
  assign ID_irom_o  = id_inst_q;
  assign ID_valid_o = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The reference model keeps the
// architectural view: a fetch PC plus a queue of fetched-but-undelivered
// instruction addresses, and the contents of the ID slot.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RPC    = 32'h0000_0000;
  localparam logic [1:0]  NORMAL = 2'b00;
  localparam logic [1:0]  STOP   = 2'b01;
  localparam logic [1:0]  FLUSH  = 2'b10;
  localparam logic [1:0]  RSVD   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        keep_i = 1'b0;
  logic        back_i = 1'b0;
  logic [31:0] back_pc_i = '0;
  logic [1:0]  ctrl = NORMAL;
  logic        irom_en_o;
  logic [31:0] irom_addr_o;
  logic [31:0] irom_data_i = '0;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_pc4_o;
  logic [31:0] ID_irom_o;
  logic        ID_valid_o;

  int vectors = 0;
  int miscompares = 0;

  // ROM contents: word = address ^ rom_key (key 0 in the directed phase).
  logic [31:0] rom_key = '0;

  // Model state.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_id_valid;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;

  fetch_stage dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .keep_i            (keep_i),
    .back_i            (back_i),
    .back_pc_i         (back_pc_i),
    .IF_ID_data_ctrl_i (ctrl),
    .irom_en_o         (irom_en_o),
    .irom_addr_o       (irom_addr_o),
    .irom_data_i       (irom_data_i),
    .ID_pc_o           (ID_pc_o),
    .ID_pc4_o          (ID_pc4_o),
    .ID_irom_o         (ID_irom_o),
    .ID_valid_o        (ID_valid_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (irom_en_o) irom_data_i <= irom_addr_o ^ rom_key;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_q.delete();
    m_id_valid = 1'b0;
    m_id_pc = '0;
    m_id_inst = NOP;
  endtask

  // One clock edge of the architectural model, from the current inputs.
  task automatic model_edge();
    logic en;
    if (rst_i) begin
      model_reset();
    end else begin
      en = !keep_i && !back_i;
      case (ctrl)
        FLUSH: begin
          m_id_valid = 1'b0;
          m_id_inst = NOP;
          m_q.delete();
        end
        NORMAL: begin
          if (m_q.size() > 0) begin
            m_id_pc = m_q.pop_front();
            m_id_inst = m_id_pc ^ rom_key;
            m_id_valid = 1'b1;
          end else begin
            m_id_valid = 1'b0;
            m_id_inst = NOP;
          end
        end
        default: ;
      endcase
      if (back_i) m_q.delete();
      if (en) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end else if (back_i) begin
        m_pc = back_pc_i & 32'hFFFF_FFFC;
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    check("irom_en", 32'(irom_en_o), 32'(!rst_i && !keep_i && !back_i));
    check("irom_addr", irom_addr_o, m_pc);
    check("ID_valid", 32'(ID_valid_o), 32'(m_id_valid));
    check("ID_pc", ID_pc_o, m_id_pc);
    check("ID_pc4", ID_pc4_o, m_id_pc + 32'd4);
    check("ID_irom", ID_irom_o, m_id_inst);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic k, input logic b, input logic [31:0] t, input logic [1:0] c);
    keep_i = k;
    back_i = b;
    back_pc_i = t;
    ctrl = c;
  endtask

  initial begin
    int r;
    model_reset();
    @(negedge clk);
    check("rst_valid", 32'(ID_valid_o), 32'd0);
    check("rst_irom", ID_irom_o, NOP);
    check("rst_pc", ID_pc_o, 32'd0);
    check("rst_pc4", ID_pc4_o, 32'd4);
    check("rst_en", 32'(irom_en_o), 32'd0);
    compare_all();

    // Reset release and straight-line fetch.
    rst_i = 1'b0;
    drive(1'b0, 1'b0, '0, NORMAL);
    step();
    check("first_issue_addr", irom_addr_o, 32'd4);
    check("first_edge_valid", 32'(ID_valid_o), 32'd0);
    step();
    check("second_edge_pc", ID_pc_o, 32'd0);
    check("second_edge_valid", 32'(ID_valid_o), 32'd1);
    step();
    check("seq_pc4", ID_pc_o, 32'd4);
    step();
    check("seq_pc8", ID_pc_o, 32'd8);
    check("seq_inst8", ID_irom_o, 32'd8);

    // Three-cycle stall with the PC held.
    drive(1'b1, 1'b0, '0, STOP);
    repeat (3) begin
      step();
      check("stall_hold_pc", ID_pc_o, 32'd8);
      check("stall_en", 32'(irom_en_o), 32'd0);
    end
    drive(1'b0, 1'b0, '0, NORMAL);
    step();
    check("release_pc12", ID_pc_o, 32'd12);
    check("release_inst12", ID_irom_o, 32'd12);
    step();
    check("release_pc16", ID_pc_o, 32'd16);

    // Redirect with flush.
    drive(1'b0, 1'b1, 32'h100, FLUSH);
    step();
    check("flush_valid", 32'(ID_valid_o), 32'd0);
    check("flush_irom", ID_irom_o, NOP);
    check("flush_addr", irom_addr_o, 32'h100);
    drive(1'b0, 1'b0, '0, NORMAL);
    step();
    step();
    check("redirect_pc", ID_pc_o, 32'h100);
    check("redirect_valid", 32'(ID_valid_o), 32'd1);

    // Redirect wins over keep; target is word aligned.
    drive(1'b1, 1'b1, 32'h203, FLUSH);
    step();
    check("back_keep_addr", irom_addr_o, 32'h200);
    drive(1'b0, 1'b0, '0, NORMAL);
    step();
    step();
    check("back_keep_id_pc", ID_pc_o, 32'h200);

    // PC wrap-around.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, FLUSH);
    step();
    drive(1'b0, 1'b0, '0, NORMAL);
    step();
    check("wrap_addr", irom_addr_o, 32'h0);
    step();
    check("wrap_id_pc", ID_pc_o, 32'hFFFF_FFFC);
    check("wrap_id_pc4", ID_pc4_o, 32'h0);

    // Reset asserted mid-stall with the skid full.
    drive(1'b1, 1'b0, '0, STOP);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", 32'(ID_valid_o), 32'd0);
    check("async_rst_irom", ID_irom_o, NOP);
    check("async_rst_en", 32'(irom_en_o), 32'd0);
    model_reset();
    step();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, '0, NORMAL);
    step();
    check("restart_addr", irom_addr_o, RPC + 32'd4);
    step();
    check("restart_id_pc", ID_pc_o, RPC);
    check("restart_valid", 32'(ID_valid_o), 32'd1);

    // Randomised phase with a scrambled ROM.
    rst_i = 1'b1;
    rom_key = $urandom;
    step();
    rst_i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      rst_i = (r == 0);
      if (r < 10) begin
        drive(1'($urandom_range(0, 1)), 1'b1,
              ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
              FLUSH);
      end else if (r < 30) begin
        drive(1'b1, 1'b0, '0, ($urandom_range(0, 3) == 0) ? RSVD : STOP);
      end else if (r < 35) begin
        drive(1'($urandom_range(0, 1)), 1'b0, '0, FLUSH);
      end else if (r < 40) begin
        drive(1'b1, 1'b0, '0, NORMAL);
      end else begin
        drive(1'b0, 1'b0, '0, NORMAL);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
